// File: rtl/systolic_feed_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_feed_ctrl_if
// Bundles the source beat handshake and the input-parser drive signals used by
// systolic_feed_ctrl.
//   src_valid  : source beat available
//   src_ready  : controller accepts a beat this cycle
//   src_data   : {port-1 vector, port-0 vector}, SIZE lanes of DATA_WIDTH each
//   par_enable : shift enable to the input parser
//   par_tile   : tile select to the input parser (constant for a job)
//   par_in_0   : parser port-0 data
//   par_in_1   : parser port-1 data
// Modports:
//   slave  : the controller's view (consumes source beats, drives the parser)
//   master : the environment's view (produces source beats, observes parser)
// ---------------------------------------------------------------------------
interface systolic_feed_ctrl_if #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 16
);

  logic                           src_valid;
  logic                           src_ready;
  logic [2*SIZE*DATA_WIDTH-1:0]   src_data;
  logic                           par_enable;
  logic                           par_tile;
  logic [SIZE*DATA_WIDTH-1:0]     par_in_0;
  logic [SIZE*DATA_WIDTH-1:0]     par_in_1;

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready,
    output par_enable,
    output par_tile,
    output par_in_0,
    output par_in_1
  );

  modport master (
    output src_valid,
    output src_data,
    input  src_ready,
    input  par_enable,
    input  par_tile,
    input  par_in_0,
    input  par_in_1
  );

endinterface

// File: rtl/systolic_feed_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_feed_ctrl
// Feeds a SIZE x SIZE systolic array input parser from a streaming source.
// A job loads k_len source beats into the parser (stalling the parser
// shifters whenever the source stalls), then flushes zeros through the skew
// so the last beat reaches the far edge of the array, then pulses done.
// In tiled mode (4 x 8x8) both parser ports carry data and the skew is only
// half as deep, so the flush is shorter.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset, aborts any job
//   start     : one-cycle job request, honoured only when idle
//   k_len     : number of source beats in the job (0 = empty job)
//   tile_req  : 0 = one 16x16 job, 1 = tiled 4x(8x8) job
//   bus       : source handshake + parser drive (slave modport)
//   busy      : registered, high from job acceptance through the done cycle
//   done      : one-cycle pulse at job end
// ---------------------------------------------------------------------------
module systolic_feed_ctrl #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 16,
  parameter int KW         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  tile_req,
  systolic_feed_ctrl_if.slave   bus,
  output logic                  busy,
  output logic                  done
);

  localparam int VW = SIZE * DATA_WIDTH;
  // Wide enough to hold 2*SIZE-1, the longest flush.
  localparam int FW = $clog2(2 * SIZE);

  localparam logic [FW-1:0] FLUSH_LAST_FULL = FW'(2 * SIZE - 2);
  localparam logic [FW-1:0] FLUSH_LAST_TILE = FW'(SIZE - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          tile_q;
  logic          busy_q;

  logic          xfer;
  logic          last_beat;
  logic          flush_end;
  logic [FW-1:0] flush_last;

  assign xfer       = (state == LOAD) && bus.src_valid;
  // k_q is never 0 in LOAD, so k_q-1 cannot underflow; comparing against
  // k_q-1 keeps the count inside KW bits even for k_len = 2^KW-1.
  assign last_beat  = xfer && (beat_cnt == (k_q - 1'b1));
  assign flush_last = tile_q ? FLUSH_LAST_TILE : FLUSH_LAST_FULL;
  assign flush_end  = (state == FLUSH) && (flush_cnt == flush_last);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_len == '0) ? DONE : LOAD;
      LOAD:    if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, counters, latched job parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      k_q       <= '0;
      tile_q    <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      if ((state == IDLE) && start) begin
        k_q      <= k_len;
        tile_q   <= tile_req;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (last_beat) begin
        flush_cnt <= '0;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Parser drive is a pure decode of state so that reset clears it at once.
  // In LOAD the enable follows src_valid, freezing the skew on source stalls.
  always_comb begin
    bus.src_ready  = 1'b0;
    bus.par_enable = 1'b0;
    bus.par_in_0   = '0;
    bus.par_in_1   = '0;
    if (state == LOAD) begin
      bus.src_ready  = 1'b1;
      bus.par_enable = bus.src_valid;
      bus.par_in_0   = bus.src_data[VW-1:0];
      if (tile_q) bus.par_in_1 = bus.src_data[2*VW-1:VW];
    end else if (state == FLUSH) begin
      bus.par_enable = 1'b1;
    end
  end

  assign bus.par_tile = tile_q;
  assign busy         = busy_q;
  assign done         = (state == DONE);

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter SIZE, default 16, PE array edge; the 16x16 input parser is fed SIZE lanes per port.
REQ-002 Parameter DATA_WIDTH, default 16, bits per lane element.
REQ-003 Parameter KW, default 8, width of the vector-count field.
REQ-004 Port clk input 1: single clock; all state updates on posedge clk.
REQ-005 Port rst_n input 1: reset, asynchronous and active-low.
REQ-006 Port start input 1: one-cycle request to begin a feed job; sampled only in IDLE.
REQ-007 Port k_len input KW: number of source beats in the job; sampled with start.
REQ-008 Port tile_req input 1: 0 = one 16x16 job, 1 = tiled 4x(8x8) mode; sampled with start.
REQ-009 Port src_valid input 1: source beat available.
REQ-010 Port src_ready output 1: controller accepts a beat this cycle.
REQ-011 Port src_data input 2*SIZE*DATA_WIDTH: low half is the port-0 vector, high half is the port-1 vector.
REQ-012 Port par_enable output 1: shift enable to the input parser.
REQ-013 Port par_tile output 1: tile select to the input parser.
REQ-014 Port par_in_0 output SIZE*DATA_WIDTH: parser port-0 data.
REQ-015 Port par_in_1 output SIZE*DATA_WIDTH: parser port-1 data.
REQ-016 Port busy output 1: job in progress.
REQ-017 Port done output 1: one-cycle pulse at job end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE, encoded in 2 bits.
REQ-019 In IDLE with start=1 and k_len!=0, the FSM SHALL latch k_len and tile_req, clear beat_cnt, and enter LOAD.
REQ-020 In IDLE with start=1 and k_len==0, the FSM SHALL go directly to DONE with par_enable held 0.
REQ-021 In LOAD, src_ready SHALL be 1 combinationally; in every other state it SHALL be 0.
REQ-022 A beat SHALL transfer on any cycle where src_valid and src_ready are both 1; each transfer increments beat_cnt by 1.
REQ-023 In LOAD, par_enable SHALL equal src_valid, so the parser shifters freeze on source stalls and no bubble enters the skew.
REQ-024 On the transfer that makes beat_cnt equal the latched k_len, the FSM SHALL enter FLUSH and clear flush_cnt.
REQ-025 In FLUSH, par_enable SHALL be 1 every cycle and par_in_0/par_in_1 SHALL be all zeros.
REQ-026 FLUSH length SHALL be 2*SIZE-1 cycles when tile=0 and SIZE-1 cycles when tile=1; flush_cnt counts from 0 up to length-1, then the FSM goes to DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then the FSM returns to IDLE.
REQ-028 In LOAD, par_in_0 SHALL equal the low half of src_data.
REQ-029 In LOAD, par_in_1 SHALL equal the high half of src_data when tile=1, and SHALL be all zeros when tile=0.
REQ-030 Outside LOAD and FLUSH, par_enable SHALL be 0 and par_in_0/par_in_1 SHALL be zero.
REQ-031 par_tile SHALL be a register loaded only at job start, and SHALL stay constant for the whole job.
REQ-032 busy SHALL be registered and SHALL be 1 in LOAD, FLUSH and DONE, and 0 in IDLE.
REQ-033 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-034 beat_cnt SHALL be KW bits wide; k_len = 2^KW-1 SHALL complete without wrap.
REQ-035 flush_cnt SHALL be wide enough for 2*SIZE-1.

Reset
REQ-036 While rst_n=0, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-037 While rst_n=0, par_tile, busy and done SHALL be 0, and par_enable and src_ready SHALL be 0.
REQ-038 Reset asserted mid-job SHALL abort the job immediately, with no done pulse.
REQ-039 After reset releases, the first start SHALL be honored on the first clock edge.

Verification
REQ-040 Basic: tile_req=0, k_len=4, src_valid held 1 -> src_ready high 4 cycles, par_in_1=0, then 31 zero-data enable cycles, then done one cycle; busy high for 36 cycles total.
REQ-041 Stall: k_len=3 with src_valid pattern 1,0,0,1,1 -> par_enable mirrors the pattern, exactly 3 transfers, FLUSH starts the cycle after the 3rd transfer.
REQ-042 Tile: tile_req=1, k_len=2 -> par_tile=1 throughout, par_in_1 equals the src_data high half, FLUSH lasts 15 cycles.
REQ-043 Zero length: start with k_len=0 -> done the next cycle, par_enable never 1, busy high 1 cycle.
REQ-044 Abort: rst_n low during FLUSH -> all outputs 0 asynchronously, no done; a new start after release completes normally.
REQ-045 Ignored start: start pulsed in LOAD with different k_len/tile_req -> the current job is unchanged and no second job runs.
